// File: rtl/reg_wr_arbiter.sv
// rtl/reg_wr_arbiter.sv - round-robin arbiter with timed lock for the register-file write port
// Optional macro REGARB_ZERO_FILTER_EN suppresses RegWr for writes to register 0.
module reg_wr_arbiter #(
    parameter int NREQ     = 2,
    parameter int n        = 32,
    parameter int LOCK_MAX = 8,
    parameter int WCNT_W   = 16
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*5-1:0] req_addr,
    input  logic [NREQ*n-1:0] req_data,
    input  logic [NREQ-1:0]   req_lock,
    output logic [NREQ-1:0]   req_ready,
    output logic [4:0]        Rw,
    output logic              RegWr,
    output logic [n-1:0]      busW,
    output logic              locked,
    output logic [WCNT_W-1:0] wr_count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

    typedef enum logic {ARB, LOCKED} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [TW-1:0] timer;
    logic [PW-1:0] win;
    logic          xfer;
    logic          issue;
    logic [4:0]    win_addr;
    logic [n-1:0]  win_data;

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int k);
        int s;
        s = (int'(p) + k) % NREQ;
        return PW'(s);
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(NREQ - 1)) ? '0 : p + PW'(1);
    endfunction

    // Scan from the highest offset down so the requester closest to ptr wins.
    always_comb begin
        req_ready = '0;
        win       = ptr;
        xfer      = 1'b0;
        if (Reset_n) begin
            if (state == LOCKED) begin
                win  = owner;
                xfer = req_valid[owner];
            end else begin
                for (int k = NREQ - 1; k >= 0; k--) begin
                    if (req_valid[rr_idx(ptr, k)]) begin
                        win  = rr_idx(ptr, k);
                        xfer = 1'b1;
                    end
                end
            end
            if (xfer) begin
                req_ready[win] = 1'b1;
            end
        end
    end

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                win_addr = req_addr[5*i +: 5];
                win_data = req_data[n*i +: n];
            end
        end
    end

`ifdef REGARB_ZERO_FILTER_EN
    assign issue = xfer && (win_addr != 5'd0);
`else
    assign issue = xfer;
`endif

    assign locked = (state == LOCKED);

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            Rw       <= '0;
            RegWr    <= 1'b0;
            busW     <= '0;
            wr_count <= '0;
            ptr      <= '0;
            owner    <= '0;
            timer    <= '0;
            state    <= ARB;
        end else begin
            RegWr    <= issue;
            wr_count <= wr_count + {{(WCNT_W-1){1'b0}}, RegWr};
            if (xfer) begin
                Rw   <= win_addr;
                busW <= win_data;
            end
            case (state)
                ARB: begin
                    if (xfer) begin
                        if (req_lock[win]) begin
                            state <= LOCKED;
                            owner <= win;
                            timer <= '0;
                        end else begin
                            ptr <= next_ptr(win);
                        end
                    end
                end
                LOCKED: begin
                    timer <= timer + TW'(1);
                    // Timeout releases even if the owner is still transferring.
                    if ((timer == TW'(LOCK_MAX - 1)) || (xfer && !req_lock[owner])) begin
                        state <= ARB;
                        ptr   <= next_ptr(owner);
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// tb/tb_reg_wr_arbiter.sv - scoreboard bench for reg_wr_arbiter
module tb_reg_wr_arbiter;

    localparam int NREQ = 2;
    localparam int N    = 32;
    localparam int LM   = 4;
    localparam int WW   = 16;

    logic              Clock = 1'b0;
    logic              Reset_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*5-1:0] req_addr;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ-1:0]   req_lock;
    logic [NREQ-1:0]   req_ready;
    logic [4:0]        Rw;
    logic              RegWr;
    logic [N-1:0]      busW;
    logic              locked;
    logic [WW-1:0]     wr_count;

    typedef struct packed {
        logic [4:0]   a;
        logic [N-1:0] d;
    } wr_t;

    wr_t          sb[$];
    wr_t          e;
    logic [N-1:0] mem [32];
    int           checks = 0;
    int           fails  = 0;
    int           exp_wc = 0;

    reg_wr_arbiter #(.NREQ(NREQ), .n(N), .LOCK_MAX(LM), .WCNT_W(WW)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_lock(req_lock), .req_ready(req_ready), .Rw(Rw),
        .RegWr(RegWr), .busW(busW), .locked(locked), .wr_count(wr_count)
    );

    always #5 Clock = ~Clock;

    // Register-file model captures on the negedge and checks each pulse against the scoreboard.
    always @(negedge Clock) begin
        if (RegWr === 1'b1) begin
            mem[Rw] = busW;
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: Rw=%0d busW=%h, expected no write", Rw, busW);
            end else begin
                e = sb.pop_front();
                if (Rw !== e.a || busW !== e.d) begin
                    fails++;
                    $display("FAIL sb_write: Rw=%0d busW=%h, expected Rw=%0d busW=%h", Rw, busW, e.a, e.d);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic setr(input int i, input logic v, input logic l, input logic [4:0] a, input logic [N-1:0] d);
        req_valid[i]       = v;
        req_lock[i]        = l;
        req_addr[5*i +: 5] = a;
        req_data[N*i +: N] = d;
    endtask

    task automatic push(input logic [4:0] a, input logic [N-1:0] d);
        sb.push_back({a, d});
        exp_wc++;
    endtask

    task automatic test_reset();
        Reset_n   = 1'b0;
        req_valid = '1;
        req_lock  = '0;
        req_addr  = {5'd2, 5'd1};
        req_data  = '1;
        repeat (2) begin
            #1;
            checks++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b, expected 00", req_ready); end
            cyc();
        end
        checks++; if (RegWr !== 1'b0) begin fails++; $display("FAIL reset_regwr: got %b, expected 0", RegWr); end
        checks++; if (Rw !== 5'd0) begin fails++; $display("FAIL reset_rw: got %0d, expected 0", Rw); end
        checks++; if (busW !== '0) begin fails++; $display("FAIL reset_busw: got %h, expected 0", busW); end
        checks++; if (wr_count !== '0) begin fails++; $display("FAIL reset_wr_count: got %0d, expected 0", wr_count); end
        checks++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b, expected 0", locked); end
        req_valid = '0;
        Reset_n   = 1'b1;
        exp_wc    = 0;
        cyc();
    endtask

    task automatic test_round_robin();
        logic [1:0] er;
        logic [4:0] ea;
        setr(0, 1'b1, 1'b0, 5'd5, 32'hAAAA);
        setr(1, 1'b1, 1'b0, 5'd6, 32'hBBBB);
        for (int c = 0; c < 4; c++) begin
            er = (c % 2 == 0) ? 2'b01 : 2'b10;
            ea = (c % 2 == 0) ? 5'd5 : 5'd6;
            #1;
            checks++; if (req_ready !== er) begin fails++; $display("FAIL rr_ready c%0d: got %b, expected %b", c, req_ready, er); end
            push(ea, (c % 2 == 0) ? 32'hAAAA : 32'hBBBB);
            cyc();
            checks++; if (RegWr !== 1'b1 || Rw !== ea) begin fails++; $display("FAIL rr_port c%0d: got RegWr=%b Rw=%0d, expected 1 %0d", c, RegWr, Rw, ea); end
        end
        req_valid = '0;
        cyc();
        cyc();
        checks++; if (mem[5] !== 32'hAAAA) begin fails++; $display("FAIL rr_mem5: got %h, expected aaaa", mem[5]); end
        checks++; if (mem[6] !== 32'hBBBB) begin fails++; $display("FAIL rr_mem6: got %h, expected bbbb", mem[6]); end
        checks++; if (wr_count !== WW'(exp_wc)) begin fails++; $display("FAIL rr_wr_count: got %0d, expected %0d", wr_count, exp_wc); end
    endtask

    task automatic test_lock();
        logic [1:0] er;
        logic       el;
        setr(1, 1'b1, 1'b0, 5'd7, 32'h1111);
        for (int c = 0; c < 5; c++) begin
            setr(0, 1'b1, (c < 3), 5'd8, 32'h100 + c);
            er = (c < 4) ? 2'b01 : 2'b10;
            el = (c >= 1 && c <= 3);
            #1;
            checks++; if (req_ready !== er) begin fails++; $display("FAIL lock_ready c%0d: got %b, expected %b", c, req_ready, er); end
            checks++; if (locked !== el) begin fails++; $display("FAIL lock_state c%0d: got %b, expected %b", c, locked, el); end
            if (c < 4) push(5'd8, 32'h100 + c);
            else push(5'd7, 32'h1111);
            cyc();
        end
        req_valid = '0;
        req_lock  = '0;
        cyc();
        cyc();
        checks++; if (wr_count !== WW'(exp_wc)) begin fails++; $display("FAIL lock_wr_count: got %0d, expected %0d", wr_count, exp_wc); end
    endtask

    task automatic test_timeout();
        setr(0, 1'b1, 1'b1, 5'd9, 32'h2222);
        setr(1, 1'b1, 1'b0, 5'd10, 32'h3333);
        #1;
        checks++; if (req_ready !== 2'b01) begin fails++; $display("FAIL to_first_ready: got %b, expected 01", req_ready); end
        push(5'd9, 32'h2222);
        cyc();
        setr(0, 1'b0, 1'b0, 5'd9, 32'h2222);
        for (int c = 1; c <= LM; c++) begin
            #1;
            checks++; if (locked !== 1'b1) begin fails++; $display("FAIL to_locked c%0d: got %b, expected 1", c, locked); end
            checks++; if (req_ready !== 2'b00) begin fails++; $display("FAIL to_ready c%0d: got %b, expected 00", c, req_ready); end
            checks++; if (RegWr !== (c == 1)) begin fails++; $display("FAIL to_regwr c%0d: got %b, expected %b", c, RegWr, (c == 1)); end
            cyc();
        end
        #1;
        checks++; if (locked !== 1'b0) begin fails++; $display("FAIL to_release: got %b, expected 0", locked); end
        checks++; if (req_ready !== 2'b10) begin fails++; $display("FAIL to_req1_ready: got %b, expected 10", req_ready); end
        push(5'd10, 32'h3333);
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        checks++; if (wr_count !== WW'(exp_wc)) begin fails++; $display("FAIL to_wr_count: got %0d, expected %0d", wr_count, exp_wc); end
    endtask

    task automatic test_single();
        setr(0, 1'b1, 1'b0, 5'd3, 32'h1234);
        #1;
        checks++; if (req_ready !== 2'b01) begin fails++; $display("FAIL single_ready: got %b, expected 01", req_ready); end
        push(5'd3, 32'h1234);
        cyc();
        req_valid = '0;
        checks++; if (RegWr !== 1'b1 || Rw !== 5'd3 || busW !== 32'h1234) begin fails++; $display("FAIL single_port: got %b %0d %h, expected 1 3 1234", RegWr, Rw, busW); end
        cyc();
        checks++; if (RegWr !== 1'b0 || Rw !== 5'd3 || busW !== 32'h1234) begin fails++; $display("FAIL single_hold: got %b %0d %h, expected 0 3 1234", RegWr, Rw, busW); end
        cyc();
        checks++; if (wr_count !== WW'(exp_wc)) begin fails++; $display("FAIL single_wr_count: got %0d, expected %0d", wr_count, exp_wc); end
    endtask

    task automatic test_zero_addr();
        setr(1, 1'b1, 1'b0, 5'd0, 32'hFFFF);
        #1;
        checks++; if (req_ready !== 2'b10) begin fails++; $display("FAIL zero_ready: got %b, expected 10", req_ready); end
`ifdef REGARB_ZERO_FILTER_EN
        cyc();
        checks++; if (RegWr !== 1'b0 || Rw !== 5'd0 || busW !== 32'hFFFF) begin fails++; $display("FAIL zero_port: got %b %0d %h, expected 0 0 ffff", RegWr, Rw, busW); end
`else
        push(5'd0, 32'hFFFF);
        cyc();
        checks++; if (RegWr !== 1'b1 || Rw !== 5'd0 || busW !== 32'hFFFF) begin fails++; $display("FAIL zero_port: got %b %0d %h, expected 1 0 ffff", RegWr, Rw, busW); end
`endif
        req_valid = '0;
        cyc();
        cyc();
        checks++; if (wr_count !== WW'(exp_wc)) begin fails++; $display("FAIL zero_wr_count: got %0d, expected %0d", wr_count, exp_wc); end
    endtask

    task automatic test_reset_mid_burst();
        setr(0, 1'b1, 1'b1, 5'd11, 32'h4444);
        #1;
        checks++; if (req_ready !== 2'b01) begin fails++; $display("FAIL mid_ready: got %b, expected 01", req_ready); end
        push(5'd11, 32'h4444);
        cyc();
        Reset_n = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b00 || locked !== 1'b1) begin fails++; $display("FAIL mid_in_reset: got ready=%b locked=%b, expected 00 1", req_ready, locked); end
        cyc();
        checks++; if (locked !== 1'b0 || RegWr !== 1'b0 || wr_count !== '0) begin fails++; $display("FAIL mid_after_reset: got %b %b %0d, expected 0 0 0", locked, RegWr, wr_count); end
        exp_wc    = 0;
        Reset_n   = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        cyc();
    endtask

    task automatic test_back_to_back();
        setr(0, 1'b1, 1'b0, 5'd12, 32'h5555);
        setr(1, 1'b1, 1'b0, 5'd12, 32'h6666);
        #1;
        checks++; if (req_ready !== 2'b01) begin fails++; $display("FAIL b2b_ready0: got %b, expected 01", req_ready); end
        push(5'd12, 32'h5555);
        cyc();
        checks++; if (RegWr !== 1'b1 || busW !== 32'h5555) begin fails++; $display("FAIL b2b_port0: got %b %h, expected 1 5555", RegWr, busW); end
        #1;
        checks++; if (req_ready !== 2'b10) begin fails++; $display("FAIL b2b_ready1: got %b, expected 10", req_ready); end
        push(5'd12, 32'h6666);
        cyc();
        checks++; if (RegWr !== 1'b1 || busW !== 32'h6666) begin fails++; $display("FAIL b2b_port1: got %b %h, expected 1 6666", RegWr, busW); end
        req_valid = '0;
        cyc();
        cyc();
        checks++; if (mem[12] !== 32'h6666) begin fails++; $display("FAIL b2b_last_wins: got %h, expected 6666", mem[12]); end
        checks++; if (wr_count !== WW'(exp_wc)) begin fails++; $display("FAIL b2b_wr_count: got %0d, expected %0d", wr_count, exp_wc); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_timeout();
        test_single();
        test_zero_addr();
        test_reset_mid_burst();
        test_back_to_back();
        checks++; if (sb.size() != 0) begin fails++; $display("FAIL sb_drained: got %0d pending, expected 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
